// File: rtl/fpalu_accum_if.sv
// rtl/fpalu_accum_if.sv - input beat and result handshakes of the FP accumulator
interface fpalu_accum_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_inf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_inf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_inf
  );
endinterface

// File: rtl/fpalu_accum.sv
// rtl/fpalu_accum.sv - streaming single-precision accumulator feeding an external combinational FP adder
module fpalu_accum #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fpalu_accum_if.slave        io,
  output logic [31:0]         add_a,
  output logic [31:0]         add_b,
  input  logic [31:0]         add_sum,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] count;
  logic             inf;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             beat;
  logic             in_exp_ff;
  logic             sum_exp_ff;
  logic [CNT_W-1:0] count_inc;

  assign beat       = io.in_valid && in_ready_q;
  assign in_exp_ff  = (io.in_data[30:23] == 8'hFF);
  assign sum_exp_ff = (add_sum[30:23] == 8'hFF);
  // Saturate rather than wrap so long packets never report a small count.
  assign count_inc  = (count == {CNT_W{1'b1}}) ? count : count + 1'b1;

  assign add_a        = acc;
  assign add_b        = io.in_data;
  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_sum   = acc;
  assign io.out_count = count;
  assign io.out_inf   = inf;
  assign busy         = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= 32'h0;
      count       <= '0;
      inf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            // First operand bypasses the adder so a lone value is returned bit-exact.
            acc    <= io.in_data;
            count  <= {{(CNT_W-1){1'b0}}, 1'b1};
            inf    <= in_exp_ff;
            busy_q <= 1'b1;
            if (io.in_last) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= add_sum;
            count <= count_inc;
            inf   <= inf | in_exp_ff | sum_exp_ff;
            if (io.in_last) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state       <= IDLE;
            acc         <= 32'h0;
            count       <= '0;
            inf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
